// File: rtl/default_slave_w.sv
// -----------------------------------------------------------------------------
// default_slave_w
//
// Write-side default slave of the AXI interconnect. Any write whose address
// decodes to no real slave is steered here. The block accepts the address,
// swallows every data beat of the burst and answers with a DECERR write
// response, so the master always sees a complete, protocol-correct handshake.
// Payload fields (address, size, burst type, data, strobes) are discarded.
//
// Ports
//   clk               in   clock, all state changes on the rising edge
//   rst               in   synchronous, active-high reset
//   AWID_SDEFAULT     in   write ID, captured on the AW handshake
//   AWADDR_SDEFAULT   in   ignored
//   AWLEN_SDEFAULT    in   burst length minus one, captured on AW handshake
//   AWSIZE_SDEFAULT   in   ignored
//   AWBURST_SDEFAULT  in   ignored
//   AWVALID_SDEFAULT  in   address valid
//   AWREADY_SDEFAULT  out  address ready (IDLE only)
//   WDATA_SDEFAULT    in   discarded
//   WSTRB_SDEFAULT    in   discarded
//   WLAST_SDEFAULT    in   last beat marker from the master
//   WVALID_SDEFAULT   in   data valid
//   WREADY_SDEFAULT   out  data ready (DATA only)
//   BID_SDEFAULT      out  response ID (the captured AWID)
//   BRESP_SDEFAULT    out  2'b11 while BVALID is high, 2'b00 otherwise
//   BVALID_SDEFAULT   out  response valid (RESP only)
//   BREADY_SDEFAULT   in   response ready
//   WLAST_ERR         out  one-cycle pulse when WLAST and the beat count
//                          disagree on the terminating beat
// -----------------------------------------------------------------------------
module default_slave_w (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [7:0]                AWID_SDEFAULT,
    input  logic [31:0]               AWADDR_SDEFAULT,
    input  logic [3:0]                AWLEN_SDEFAULT,
    input  logic [2:0]                AWSIZE_SDEFAULT,
    input  logic [1:0]                AWBURST_SDEFAULT,
    input  logic                      AWVALID_SDEFAULT,
    output logic                      AWREADY_SDEFAULT,

    input  logic [31:0]               WDATA_SDEFAULT,
    input  logic [3:0]                WSTRB_SDEFAULT,
    input  logic                      WLAST_SDEFAULT,
    input  logic                      WVALID_SDEFAULT,
    output logic                      WREADY_SDEFAULT,

    output logic [7:0]                BID_SDEFAULT,
    output logic [1:0]                BRESP_SDEFAULT,
    output logic                      BVALID_SDEFAULT,
    input  logic                      BREADY_SDEFAULT,

    output logic                      WLAST_ERR
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_q,      state_d;
    logic [7:0]  id_q,         id_d;
    logic [3:0]  len_q,        len_d;
    logic [3:0]  beat_cnt_q,   beat_cnt_d;
    logic        wlast_err_q,  wlast_err_d;

    // Handshake readies/valids, decoded purely from the state register and
    // forced low while reset is held so nothing handshakes during reset.
    logic aw_ready;
    logic w_ready;
    logic b_valid;

    assign aw_ready = (state_q == IDLE) && !rst;
    assign w_ready  = (state_q == DATA) && !rst;
    assign b_valid  = (state_q == RESP) && !rst;

    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign aw_hs = AWVALID_SDEFAULT && aw_ready;
    assign w_hs  = WVALID_SDEFAULT  && w_ready;
    assign b_hs  = BREADY_SDEFAULT  && b_valid;

    // Count-based end of burst: the current beat is the one AWLEN promised
    // as the last. Combined with WLAST it decides termination and the
    // mismatch diagnostic.
    logic cnt_last;
    assign cnt_last = (beat_cnt_q == len_q);

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        wlast_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d       = AWID_SDEFAULT;
                    len_d      = AWLEN_SDEFAULT;
                    beat_cnt_d = 4'd0;
                    state_d    = DATA;
                end
            end

            DATA: begin
                if (w_hs) begin
                    // Either indication ends the burst; the master is never
                    // left waiting on a beat count it does not agree with.
                    if (WLAST_SDEFAULT || cnt_last) begin
                        state_d     = RESP;
                        wlast_err_d = WLAST_SDEFAULT ^ cnt_last;
                    end else begin
                        // beat_cnt_q < len_q here, so this cannot wrap.
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end

            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= 8'd0;
            len_q       <= 4'd0;
            beat_cnt_q  <= 4'd0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign AWREADY_SDEFAULT = aw_ready;
    assign WREADY_SDEFAULT  = w_ready;
    assign BVALID_SDEFAULT  = b_valid;
    assign BID_SDEFAULT     = id_q;
    assign BRESP_SDEFAULT   = b_valid ? RESP_DECERR : RESP_OKAY;
    assign WLAST_ERR        = wlast_err_q;

    // Payload fields carry no meaning for a terminating slave.
    logic unused_payload;
    assign unused_payload = ^{AWADDR_SDEFAULT, AWSIZE_SDEFAULT,
                              AWBURST_SDEFAULT, WDATA_SDEFAULT,
                              WSTRB_SDEFAULT};

endmodule

// File: tb/tb_default_slave_w.sv
module tb_default_slave_w;

    logic        clk;
    logic        rst;
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        wlast_err;

    int tests_run;
    int tests_failed;

    default_slave_w dut (
        .clk              (clk),
        .rst              (rst),
        .AWID_SDEFAULT    (awid),
        .AWADDR_SDEFAULT  (awaddr),
        .AWLEN_SDEFAULT   (awlen),
        .AWSIZE_SDEFAULT  (awsize),
        .AWBURST_SDEFAULT (awburst),
        .AWVALID_SDEFAULT (awvalid),
        .AWREADY_SDEFAULT (awready),
        .WDATA_SDEFAULT   (wdata),
        .WSTRB_SDEFAULT   (wstrb),
        .WLAST_SDEFAULT   (wlast),
        .WVALID_SDEFAULT  (wvalid),
        .WREADY_SDEFAULT  (wready),
        .BID_SDEFAULT     (bid),
        .BRESP_SDEFAULT   (bresp),
        .BVALID_SDEFAULT  (bvalid),
        .BREADY_SDEFAULT  (bready),
        .WLAST_ERR        (wlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven, and registered outputs sampled, 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({awready, wready, bvalid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_handshake: got aw/w/b=%b required 000", {awready, wready, bvalid});
        end
        tests_run++;
        if ({bid, bresp, wlast_err} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: got bid=%h bresp=%b werr=%b required 00/00/0", bid, bresp, wlast_err);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_awready: got %b required 1", awready);
        end
        $display("[TB] reset: aw/w/b after release = %b%b%b", awready, wready, bvalid);
    endtask

    task automatic test_single_beat();
        awid = 8'h15; awlen = 4'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tests_run++;
        if ({awready, wready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_data_state: got awready/wready=%b%b required 01", awready, wready);
        end
        wvalid = 1'b1; wlast = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        tests_run++;
        if ({bvalid, wready, bid, bresp, wlast_err} !== {1'b1, 1'b0, 8'h15, 2'b11, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_resp: got bv=%b wr=%b bid=%h bresp=%b werr=%b required 1 0 15 11 0",
                     bvalid, wready, bid, bresp, wlast_err);
        end
        tick();
        bready = 1'b0;
        tests_run++;
        if ({awready, bvalid, bresp} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL single_back_idle: got awready=%b bvalid=%b bresp=%b required 1 0 00", awready, bvalid, bresp);
        end
        $display("[TB] single beat: id=15 len=0 done, bid=%h", bid);
    endtask

    task automatic test_burst_toggle();
        logic [5:0] pattern;
        int beats;
        pattern = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
        beats = 0;
        awid = 8'h42; awlen = 4'd3; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wvalid = pattern[i];
            wlast  = pattern[i] && (beats == 3);
            wdata  = 32'h1000 + i;
            tick();
            if (pattern[i]) beats++;
            if (i == 4) begin
                tests_run++;
                if ({wready, bvalid} !== 2'b10) begin
                    tests_failed++;
                    $display("FAIL burst_still_data_after3: got wready=%b bvalid=%b required 1 0", wready, bvalid);
                end
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        tests_run++;
        if ({bvalid, wready, bid, bresp, wlast_err} !== {1'b1, 1'b0, 8'h42, 2'b11, 1'b0}) begin
            tests_failed++;
            $display("FAIL burst_resp: got bv=%b wr=%b bid=%h bresp=%b werr=%b required 1 0 42 11 0",
                     bvalid, wready, bid, bresp, wlast_err);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        $display("[TB] burst toggle: %0d beats sent, awready=%b", beats, awready);
    endtask

    task automatic test_early_wlast();
        awid = 8'h3C; awlen = 4'd3; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b0;
        tick();
        tests_run++;
        if ({wready, wlast_err} !== 2'b10) begin
            tests_failed++;
            $display("FAIL early_beat1: got wready=%b werr=%b required 1 0", wready, wlast_err);
        end
        wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        tests_run++;
        if ({bvalid, bresp, wlast_err} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL early_resp: got bv=%b bresp=%b werr=%b required 1 11 1", bvalid, bresp, wlast_err);
        end
        tick();
        tests_run++;
        if ({bvalid, wlast_err} !== 2'b10) begin
            tests_failed++;
            $display("FAIL early_pulse_width: got bv=%b werr=%b required 1 0", bvalid, wlast_err);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        $display("[TB] early wlast: id=3C terminated after beat 2");
    endtask

    task automatic test_missing_wlast();
        awid = 8'h81; awlen = 4'd1; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b0;
        tick();
        tick();
        // Third beat stays presented; it must not be taken.
        tests_run++;
        if ({bvalid, wready, bid, wlast_err} !== {1'b1, 1'b0, 8'h81, 1'b1}) begin
            tests_failed++;
            $display("FAIL missing_resp: got bv=%b wr=%b bid=%h werr=%b required 1 0 81 1",
                     bvalid, wready, bid, wlast_err);
        end
        tick();
        tests_run++;
        if ({bvalid, wready, wlast_err} !== 3'b100) begin
            tests_failed++;
            $display("FAIL missing_extra_beat: got bv=%b wr=%b werr=%b required 1 0 0", bvalid, wready, wlast_err);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        tests_run++;
        if ({awready, wready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL missing_idle_no_wready: got awready=%b wready=%b required 1 0", awready, wready);
        end
        wvalid = 1'b0;
        $display("[TB] missing wlast: id=81 terminated after beat 2");
    endtask

    task automatic test_backpressure();
        awid = 8'h5A; awlen = 4'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        awid = 8'h77; awlen = 4'd0; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({bvalid, bid, bresp, awready} !== {1'b1, 8'h5A, 2'b11, 1'b0}) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: got bv=%b bid=%h bresp=%b awr=%b required 1 5a 11 0",
                         i, bvalid, bid, bresp, awready);
            end
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        tests_run++;
        if ({awready, bvalid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL backpressure_release: got awready=%b bvalid=%b required 1 0", awready, bvalid);
        end
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        tests_run++;
        if ({bvalid, bid} !== {1'b1, 8'h77}) begin
            tests_failed++;
            $display("FAIL backpressure_second_id: got bv=%b bid=%h required 1 77", bvalid, bid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        $display("[TB] backpressure: held 5 cycles, second id=%h", bid);
    endtask

    task automatic test_reset_mid_burst();
        awid = 8'h33; awlen = 4'd3; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b0;
        tick();
        wvalid = 1'b0;
        rst = 1'b1;
        tick();
        tests_run++;
        if ({awready, wready, bvalid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got aw/w/b=%b required 000", {awready, wready, bvalid});
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({awready, wready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL midrst_idle: got awready=%b wready=%b required 1 0", awready, wready);
        end
        awid = 8'hA0; awlen = 4'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        tests_run++;
        if ({bvalid, bid, bresp} !== {1'b1, 8'hA0, 2'b11}) begin
            tests_failed++;
            $display("FAIL midrst_fresh: got bv=%b bid=%h bresp=%b required 1 a0 11", bvalid, bid, bresp);
        end
        // Reset while the response is pending drops it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({awready, bvalid, bid} !== {1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL resp_reset_drop: got awr=%b bv=%b bid=%h required 1 0 00", awready, bvalid, bid);
        end
        $display("[TB] reset mid-burst: recovered, fresh id=A0 completed");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        awid = '0; awaddr = 32'h4000_0000; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b0;
        wdata = '0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0;

        test_reset();
        test_single_beat();
        test_burst_toggle();
        test_early_wlast();
        test_missing_wlast();
        test_backpressure();
        test_reset_mid_burst();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
